// File: rtl/fifo_pkg.sv
// Shared sizing helpers for the async FIFO and its read-side stream master.
package fifo_pkg;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int x = v - 1; x > 0; x = x >> 1) r++;
    return r;
  endfunction

  // Width needed to hold 0..depth inclusive.
  function automatic int cnt_w(input int depth);
    return clog2(depth + 1);
  endfunction

  function automatic int ptr_w(input int depth);
    return (depth > 1) ? clog2(depth) : 1;
  endfunction

  // The buffer must absorb every read that can be in flight plus the word being held.
  function automatic bit depth_ok(input int depth, input int rd_latency);
    return (rd_latency >= 1) && (depth >= rd_latency + 1);
  endfunction

endpackage

// File: rtl/fifo_rd_stream_ring.sv
// Single-clock DEPTH x DATA_WIDTH ring buffer; HEAD is the oldest word, straight from storage.
module sync_ring_buf
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 3
) (
  input  logic                     CLK,
  input  logic                     RST_N,
  input  logic                     PUSH,
  input  logic [DATA_WIDTH-1:0]    PUSH_DATA,
  input  logic                     POP,
  output logic [cnt_w(DEPTH)-1:0]  COUNT,
  output logic [DATA_WIDTH-1:0]    HEAD
);

  localparam int CW = cnt_w(DEPTH);
  localparam int PW = ptr_w(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;

  // Explicit wrap so non-power-of-2 depths are legal.
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      COUNT  <= '0;
    end else begin
      if (PUSH) begin
        mem[wr_ptr] <= PUSH_DATA;
        wr_ptr      <= nxt(wr_ptr);
      end
      if (POP) rd_ptr <= nxt(rd_ptr);
      COUNT <= COUNT + CW'(PUSH) - CW'(POP);
    end
  end

  assign HEAD = mem[rd_ptr];

endmodule

// File: rtl/fifo_rd_stream.sv
// Read-side master for the async FIFO: prefetches through the RAM read latency into a
// small ring and presents registered words as a valid/ready stream.
module fifo_rd_stream
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int RD_LATENCY = 1,
  parameter int BUF_DEPTH  = 3
) (
  input  logic                          CLK,
  input  logic                          RST_N,
  input  logic                          FIFO_EMPTY,
  output logic                          FIFO_REN,
  input  logic [DATA_WIDTH-1:0]         FIFO_R_DATA,
  output logic                          M_VALID,
  input  logic                          M_READY,
  output logic [DATA_WIDTH-1:0]         M_DATA,
  output logic [cnt_w(BUF_DEPTH)-1:0]   LEVEL
);

  localparam int CW = cnt_w(BUF_DEPTH);
  localparam int IW = cnt_w(RD_LATENCY);

  if (!depth_ok(BUF_DEPTH, RD_LATENCY)) begin : g_bad_cfg
    $error("fifo_rd_stream: BUF_DEPTH must be >= RD_LATENCY+1");
  end

  logic [RD_LATENCY-1:0] vld_pipe;
  logic [IW-1:0]         inflight;
  logic [CW-1:0]         count;
  logic                  push;
  logic                  pop;

  assign push = vld_pipe[RD_LATENCY-1];
  assign pop  = M_VALID & M_READY;

  // Credit: every issued read already owns a slot, so the ring can never overflow.
  // Only registered state and EMPTY feed this; M_READY stays off the REN path.
  assign FIFO_REN = RST_N & ~FIFO_EMPTY &
                    ((int'(count) + int'(inflight)) < BUF_DEPTH);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      vld_pipe <= '0;
      inflight <= '0;
    end else begin
      vld_pipe <= (vld_pipe << 1) | RD_LATENCY'(FIFO_REN);
      inflight <= inflight + IW'(FIFO_REN) - IW'(push);
    end
  end

  sync_ring_buf #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (BUF_DEPTH)
  ) u_ring (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .PUSH      (push),
    .PUSH_DATA (FIFO_R_DATA),
    .POP       (pop),
    .COUNT     (count),
    .HEAD      (M_DATA)
  );

  assign M_VALID = (count != '0);
  assign LEVEL   = count;

  a_no_overflow: assert property (@(posedge CLK) disable iff (!RST_N)
    !(push && (count == CW'(BUF_DEPTH))));
  a_no_underflow: assert property (@(posedge CLK) disable iff (!RST_N)
    !(pop && (count == '0)));

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Bench for fifo_rd_stream: two configurations against a behavioural FIFO and an
// outstanding-words stream model, plus literal expectations for the directed scenarios.
module tb_fifo_rd_stream;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int ncheck = 0;
  int nerr   = 0;

  // Config A: defaults (L=1, D=3). Config B: L=2, D=4.
  logic       rst_a = 1'b0, mr_a = 1'b0, empty_a, ren_a, mv_a;
  logic [7:0] rdata_a, md_a, dpa;
  logic [1:0] lvl_a;
  logic       rst_b = 1'b0, mr_b = 1'b0, hold_b = 1'b0, empty_b, ren_b, mv_b;
  logic [7:0] rdata_b, md_b, dpb0, dpb1;
  logic [2:0] lvl_b;

  logic [7:0] src_a [2048];
  logic [7:0] src_b [2048];
  int sn_a = 0, lim_a = 1 << 30, srd_a;
  int sn_b = 0, lim_b = 1 << 30, srd_b;

  fifo_rd_stream dut_a (
    .CLK(clk), .RST_N(rst_a), .FIFO_EMPTY(empty_a), .FIFO_REN(ren_a),
    .FIFO_R_DATA(rdata_a), .M_VALID(mv_a), .M_READY(mr_a), .M_DATA(md_a), .LEVEL(lvl_a));

  fifo_rd_stream #(.DATA_WIDTH(8), .RD_LATENCY(2), .BUF_DEPTH(4)) dut_b (
    .CLK(clk), .RST_N(rst_b), .FIFO_EMPTY(empty_b), .FIFO_REN(ren_b),
    .FIFO_R_DATA(rdata_b), .M_VALID(mv_b), .M_READY(mr_b), .M_DATA(md_b), .LEVEL(lvl_b));

  // Behavioural FIFO read ports; junk on the bus whenever no read is returning.
  always @(posedge clk or negedge rst_a)
    if (!rst_a) begin
      srd_a <= 0;
      dpa   <= '0;
    end else begin
      if (ren_a) srd_a <= srd_a + 1;
      dpa <= ren_a ? src_a[srd_a[10:0]] : 8'($urandom);
    end
  assign rdata_a = dpa;
  assign empty_a = (srd_a >= sn_a) || (srd_a >= lim_a);

  always @(posedge clk or negedge rst_b)
    if (!rst_b) begin
      srd_b <= 0;
      dpb0  <= '0;
      dpb1  <= '0;
    end else begin
      if (ren_b) srd_b <= srd_b + 1;
      dpb0 <= ren_b ? src_b[srd_b[10:0]] : 8'($urandom);
      dpb1 <= dpb0;
    end
  assign rdata_b = dpb1;
  assign empty_b = (srd_b >= sn_b) || (srd_b >= lim_b) || hold_b;

  // Stream model state: issued reads and pops so far; recent REN history for in-flight reads.
  int         issued [2];
  int         popped [2];
  logic       hist [2][4];
  logic       prev_hold [2];
  logic [7:0] prev_md [2];
  int         cyc [2], nren [2], nbeats [2], first_ren [2], first_val [2], last_beat [2];
  logic       seen_val [2];
  logic [7:0] first_data [2];

  task automatic chk_eq(input string name, input int k, input int act, input int exp);
    ncheck++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s[%0d] got %0d expected %0d at %0t", name, k, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] exp_word(input int k, input int i);
    logic [10:0] j;
    j = i[10:0];
    return (k == 0) ? src_a[j] : src_b[j];
  endfunction

  task automatic step(input int k, input int L, input int D, input logic rst, input logic emp,
                      input logic ren, input logic mv, input logic mr, input logic [7:0] md,
                      input int lvl);
    int infl, outst;
    if (!rst) begin
      chk_eq("rst_ren", k, int'(ren), 0);
      chk_eq("rst_valid", k, int'(mv), 0);
      chk_eq("rst_level", k, lvl, 0);
      chk_eq("rst_data", k, int'(md), 0);
      issued[k] = 0; popped[k] = 0; prev_hold[k] = 1'b0;
      for (int i = 0; i < 4; i++) hist[k][i] = 1'b0;
      cyc[k] = 0; nren[k] = 0; nbeats[k] = 0; seen_val[k] = 1'b0;
      return;
    end
    infl = 0;
    for (int i = 0; i < L; i++) infl += int'(hist[k][i]);
    // Words owned by the block = issued - popped; those not yet returned are in flight.
    outst = issued[k] - popped[k];
    chk_eq("level", k, lvl, outst - infl);
    chk_eq("valid", k, int'(mv), int'((outst - infl) != 0));
    chk_eq("ren", k, int'(ren), int'(!emp && (outst < D)));
    if (prev_hold[k]) chk_eq("stable", k, int'(md), int'(prev_md[k]));
    if (mv && !seen_val[k]) begin
      seen_val[k]  = 1'b1;
      first_val[k] = cyc[k];
    end
    if (mv && mr) begin
      chk_eq("data", k, int'(md), int'(exp_word(k, popped[k])));
      if (nbeats[k] == 0) first_data[k] = md;
      nbeats[k]++;
      last_beat[k] = cyc[k];
      popped[k]++;
    end
    if (ren) begin
      if (nren[k] == 0) first_ren[k] = cyc[k];
      nren[k]++;
      issued[k]++;
    end
    prev_hold[k] = mv && !mr;
    prev_md[k]   = md;
    for (int i = 3; i > 0; i--) hist[k][i] = hist[k][i-1];
    hist[k][0] = ren;
    cyc[k]++;
  endtask

  always @(negedge clk) begin
    step(0, 1, 3, rst_a, empty_a, ren_a, mv_a, mr_a, md_a, int'(lvl_a));
    step(1, 2, 4, rst_b, empty_b, ren_b, mv_b, mr_b, md_b, int'(lvl_b));
  end

  task automatic wait_pop(input int k, input int n, input int budget);
    for (int i = 0; i < budget && popped[k] < n; i++) @(posedge clk);
    chk_eq("pop_count", k, popped[k], n);
  endtask

  initial begin
    fork
      begin : seq_a
        // Reset with data available, then full-rate drain of 0x01..0x10.
        for (int i = 0; i < 16; i++) src_a[i] = 8'(i + 1);
        sn_a = 16; mr_a = 1'b1;
        repeat (3) @(posedge clk);
        #1 chk_eq("t1_ren_in_reset", 0, int'(ren_a), 0);
        rst_a = 1'b1;
        @(negedge clk);
        chk_eq("t1_ren_first", 0, int'(ren_a), 1);
        wait_pop(0, 16, 100);
        chk_eq("t2_fill_latency", 0, first_val[0] - first_ren[0], 2);
        chk_eq("t2_nren", 0, nren[0], 16);
        chk_eq("t2_no_bubbles", 0, last_beat[0] - first_val[0], 15);
        chk_eq("t2_first_word", 0, int'(first_data[0]), 1);

        // Consumer stalled from the start.
        #1 rst_a = 1'b0;
        mr_a = 1'b0;
        @(posedge clk);
        #1 rst_a = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        chk_eq("t3_nren", 0, nren[0], 3);
        chk_eq("t3_level", 0, int'(lvl_a), 3);
        chk_eq("t3_head", 0, int'(md_a), 8'h01);
        chk_eq("t3_valid", 0, int'(mv_a), 1);
        repeat (5) @(posedge clk);
        #1 chk_eq("t3_head_held", 0, int'(md_a), 8'h01);
        mr_a = 1'b1;
        wait_pop(0, 16, 100);
        chk_eq("t3_nbeats", 0, nbeats[0], 16);

        // FIFO goes empty after 5 reads.
        #1 rst_a = 1'b0;
        for (int i = 0; i < 16; i++) src_a[i] = 8'(8'h20 + i);
        lim_a = 5;
        @(posedge clk);
        #1 rst_a = 1'b1;
        for (int c = 0; c < 40; c++) begin
          mr_a = (c < 30) ? 1'($urandom_range(0, 1)) : 1'b1;
          @(posedge clk);
          #1;
        end
        chk_eq("t4_nbeats", 0, nbeats[0], 5);
        chk_eq("t4_nren", 0, nren[0], 5);
        chk_eq("t4_valid_low", 0, int'(mv_a), 0);
      end
      begin : seq_b
        // Reset pulse with two words buffered and two in flight.
        for (int i = 0; i < 16; i++) src_b[i] = 8'(8'h80 + i);
        sn_b = 16; mr_b = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_b = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk_eq("t6_level_pre", 1, int'(lvl_b), 2);
        chk_eq("t6_nren_pre", 1, nren[1], 4);
        rst_b = 1'b0;
        #1;
        chk_eq("t6_valid_now", 1, int'(mv_b), 0);
        chk_eq("t6_level_now", 1, int'(lvl_b), 0);
        chk_eq("t6_ren_now", 1, int'(ren_b), 0);
        for (int i = 0; i < 8; i++) src_b[i] = 8'(8'hC0 + i);
        sn_b = 8; mr_b = 1'b1;
        @(posedge clk);
        #1 rst_b = 1'b1;
        wait_pop(1, 8, 100);
        chk_eq("t6_first_after", 1, int'(first_data[1]), 8'hC0);
        chk_eq("t6_nbeats", 1, nbeats[1], 8);

        // 1000 random words, random ready and random EMPTY gaps.
        #1 rst_b = 1'b0;
        for (int i = 0; i < 1000; i++) src_b[i] = 8'($urandom);
        sn_b = 1000;
        @(posedge clk);
        #1 rst_b = 1'b1;
        for (int c = 0; c < 20000 && popped[1] < 1000; c++) begin
          mr_b = 1'($urandom_range(0, 1));
          if ($urandom_range(0, 9) == 0) hold_b = !hold_b;
          @(posedge clk);
          #1;
        end
        hold_b = 1'b0;
        chk_eq("t5_words", 1, popped[1], 1000);
        chk_eq("t5_nren", 1, nren[1], 1000);
      end
    join
    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", ncheck, nerr);
    $finish;
  end

endmodule
